// File: rtl/simd_pkg.sv
// ============================================================================
// Module  : simd_pkg
// Brief   : Shared row type, drain FSM encoding and default lane geometry.
// Revision: 1.0
// ============================================================================
`default_nettype none

package simd_pkg;

  localparam int C_PE_COUNT   = 4;
  localparam int C_DATA_WIDTH = 32;

  typedef logic [C_PE_COUNT-1:0][C_DATA_WIDTH-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } drain_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_row.sv
// ============================================================================
// Module  : sync_fifo_row
// Brief   : First-word-fall-through synchronous FIFO of result rows.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo_row
  import simd_pkg::*;
#(
  parameter int PE_COUNT   = C_PE_COUNT,
  parameter int DATA_WIDTH = C_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push,
  input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  din,
  input  logic                                 pop,
  output logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  dout,
  output logic                                 empty,
  output logic [CNT_W-1:0]                     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]                    r_wr_ptr;
  logic [PTR_W-1:0]                    r_rd_ptr;
  logic [CNT_W-1:0]                    r_count;
  logic                                w_push;
  logic                                w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Overflowing pushes and underflowing pops are dropped rather than corrupting state.
  assign w_push = push && (r_count != CNT_W'(DEPTH));
  assign w_pop  = pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/result_drain.sv
// ============================================================================
// Module  : result_drain
// Brief   : Streams BRAM R result rows to a valid/ready sink via a prefetch FIFO.
//           Optional running XOR checksum output: define RESULT_DRAIN_CSUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module result_drain
  import simd_pkg::*;
#(
  parameter int PE_COUNT   = C_PE_COUNT,
  parameter int DATA_WIDTH = C_DATA_WIDTH,
  parameter int BRAM_DEPTH = 1024,
  parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH),
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [ADDR_WIDTH:0]            row_count,
  output logic                           busy,
  output logic                           done,
  output logic                           bram_r_rd_en,
  output logic [ADDR_WIDTH-1:0]          bram_r_rd_addr,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_rd_data,
  output logic [PE_COUNT*DATA_WIDTH-1:0] m_tdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           m_tlast
`ifdef RESULT_DRAIN_CSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]          csum
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 1);

  generate
    if ((RD_LAT < 1) || (FIFO_DEPTH < RD_LAT + 1)) begin : g_depth_check
      $error("result_drain: FIFO_DEPTH must be >= RD_LAT+1 and RD_LAT >= 1");
    end
  endgenerate

  drain_state_e                        r_state;
  drain_state_e                        w_state_nxt;
  logic [ADDR_WIDTH-1:0]               r_addr;
  logic [ADDR_WIDTH:0]                 r_count;
  logic [ADDR_WIDTH:0]                 r_issued;
  logic [ADDR_WIDTH:0]                 r_sent;
  logic [RD_LAT-1:0]                   r_tag;
  logic                                w_start_ok;
  logic                                w_start_rd;
  logic                                w_run_rd;
  logic                                w_hs;
  logic                                w_last_row;
  logic [OCC_W-1:0]                    w_in_flight;
  logic [OCC_W-1:0]                    w_occ;
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] w_rd_row;
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] w_head;
  logic                                w_empty;
  logic [CNT_W-1:0]                    w_fifo_count;

  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(BRAM_DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_in_flight = w_in_flight + OCC_W'(r_tag[i]);
    end
  end

  // Credit covers both queued rows and reads still in the BRAM pipe, so pushes never overflow.
  assign w_occ      = w_in_flight + OCC_W'(w_fifo_count);
  assign w_start_ok = start && (r_state == IDLE);
  // The first read goes out in the start cycle itself to shave a cycle off first-beat latency.
  assign w_start_rd = w_start_ok && (row_count != '0) && !rst;
  assign w_run_rd   = (r_state == RUN) && (r_issued < r_count) &&
                      (w_occ < OCC_W'(FIFO_DEPTH)) && !rst;
  assign w_hs       = m_tvalid && m_tready;
  assign w_last_row = (r_sent == r_count - (ADDR_WIDTH + 1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (row_count != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (w_hs && w_last_row) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy           = (r_state == RUN);
    done           = (r_state == DONE);
    bram_r_rd_en   = w_start_rd || w_run_rd;
    bram_r_rd_addr = w_start_rd ? base_addr : r_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_count  <= '0;
      r_issued <= '0;
      r_sent   <= '0;
      r_tag    <= '0;
    end else begin
      r_tag <= (r_tag << 1) | RD_LAT'(bram_r_rd_en);
      if (w_start_ok) begin
        r_count  <= row_count;
        r_sent   <= '0;
        r_issued <= (row_count != '0) ? (ADDR_WIDTH + 1)'(1) : '0;
        r_addr   <= (row_count != '0) ? addr_inc(base_addr) : base_addr;
      end else begin
        if (w_run_rd) begin
          r_addr   <= addr_inc(r_addr);
          r_issued <= r_issued + (ADDR_WIDTH + 1)'(1);
        end
        if (w_hs) begin
          r_sent <= r_sent + (ADDR_WIDTH + 1)'(1);
        end
      end
    end
  end

  assign w_rd_row = bram_r_rd_data;

  sync_fifo_row #(
    .PE_COUNT   (PE_COUNT),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_tag[RD_LAT-1]),
    .din   (w_rd_row),
    .pop   (w_hs),
    .dout  (w_head),
    .empty (w_empty),
    .count (w_fifo_count)
  );

  // Head is masked while empty so the bus reads zero instead of stale storage.
  assign m_tvalid = !w_empty;
  assign m_tdata  = w_empty ? '0 : w_head;
  assign m_tlast  = m_tvalid && w_last_row;

`ifdef RESULT_DRAIN_CSUM_EN
  logic [DATA_WIDTH-1:0] r_csum;
  logic [DATA_WIDTH-1:0] w_beat_xor;

  always_comb begin
    w_beat_xor = '0;
    for (int i = 0; i < PE_COUNT; i++) begin
      w_beat_xor = w_beat_xor ^ m_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum <= '0;
    end else if (w_start_ok) begin
      r_csum <= '0;
    end else if (w_hs) begin
      r_csum <= r_csum ^ w_beat_xor;
    end
  end

  assign csum = r_csum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_result_drain.sv
// ============================================================================
// Module  : tb_result_drain
// Brief   : Randomized self-checking bench for result_drain against a row-order model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_result_drain;
  import simd_pkg::*;

  localparam int PE     = 4;
  localparam int DW     = 32;
  localparam int DEPTH  = 1024;
  localparam int AW     = 10;
  localparam int RD_LAT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [AW:0]     row_count;
  logic            busy;
  logic            done;
  logic            bram_r_rd_en;
  logic [AW-1:0]   bram_r_rd_addr;
  logic [PE*DW-1:0] bram_r_rd_data;
  logic [PE*DW-1:0] m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
`ifdef RESULT_DRAIN_CSUM_EN
  logic [DW-1:0]   csum;
`endif

  result_drain #(
    .PE_COUNT   (PE),
    .DATA_WIDTH (DW),
    .BRAM_DEPTH (DEPTH),
    .ADDR_WIDTH (AW),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .row_count      (row_count),
    .busy           (busy),
    .done           (done),
    .bram_r_rd_en   (bram_r_rd_en),
    .bram_r_rd_addr (bram_r_rd_addr),
    .bram_r_rd_data (bram_r_rd_data),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tlast        (m_tlast)
`ifdef RESULT_DRAIN_CSUM_EN
    ,
    .csum           (csum)
`endif
  );

  always #5 clk = ~clk;

  // BRAM R model: address registered, then data registered -> two-cycle read latency.
  row_t          mem [DEPTH];
  logic [AW-1:0] r_a0;
  row_t          r_q;
  always @(posedge clk) begin
    r_a0 <= bram_r_rd_addr;
    r_q  <= mem[r_a0];
  end
  assign bram_r_rd_data = r_q;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic row_t model_row(input int base, input int k);
    row_t r;
    int   idx;
    idx = (base + k) % DEPTH;
    for (int j = 0; j < PE; j++) r[j] = 32'(4 * idx + j);
    return r;
  endfunction

  task automatic run_drain(input int base, input int cnt, input bit rnd, input int abort_at);
    int          got = 0;
    int          cyc = 0;
    int          done_cyc = -1;
    bit          seen_rd = 0, seen_v = 0, bad_done = 0, bad_v = 0;
    logic        pv = 0, pr = 0, pl = 0;
    logic [127:0] pd = '0;
    logic [31:0] xs = '0;
    row_t        beat;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = AW'(base);
    row_count = (AW + 1)'(cnt);
    m_tready  = rnd ? 1'($urandom % 2) : 1'b1;
    while (cyc < 4000) begin
      @(negedge clk);
      if (bram_r_rd_en) seen_rd = 1;
      if (m_tvalid) seen_v = 1;
      if (cyc == 0) check_eq("busy_in_start_cycle", busy, 0);
      if (cyc == 1 && cnt > 0) check_eq("busy_running", busy, 1);
      if (pv && !pr) begin
        check_eq("stall_valid", m_tvalid, 1);
        check_eq("stall_data", m_tdata, pd);
        check_eq("stall_last", m_tlast, pl);
      end
      if (m_tvalid && m_tready) begin
        if (got < cnt) begin
          check_eq("beat_data", m_tdata, model_row(base, got));
          check_eq("beat_last", m_tlast, (got == cnt - 1));
          if (!rnd) check_eq("beat_cycle", cyc, RD_LAT + 1 + got);
          beat = m_tdata;
          for (int j = 0; j < PE; j++) xs = xs ^ beat[j];
        end else begin
          check_eq("extra_beat", m_tvalid & m_tready, 0);
        end
        got++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (abort_at > 0 && got == abort_at) break;
      pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast;
      @(posedge clk); #1;
      start    = 1'b0;
      m_tready = rnd ? 1'($urandom % 2) : 1'b1;
      cyc++;
    end
    if (abort_at > 0) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst   = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (done) bad_done = 1;
        if (m_tvalid) bad_v = 1;
      end
      check_eq("abort_no_done", bad_done, 0);
      check_eq("abort_no_valid", bad_v, 0);
      check_eq("abort_idle", busy, 0);
      check_eq("abort_reached_beats", got, abort_at);
      return;
    end
    check_eq("done_seen", (done_cyc >= 0), 1);
    check_eq("beat_total", got, cnt);
    if (!rnd) check_eq("done_cycle", done_cyc, (cnt == 0) ? 1 : RD_LAT + 1 + cnt);
    if (cnt == 0) begin
      check_eq("zero_no_rd", seen_rd, 0);
      check_eq("zero_no_valid", seen_v, 0);
    end
`ifdef RESULT_DRAIN_CSUM_EN
    check_eq("csum_at_done", csum, xs);
`endif
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("done_single_pulse", done, 0);
    check_eq("idle_after_done", busy, 0);
`ifdef RESULT_DRAIN_CSUM_EN
    check_eq("csum_held", csum, xs);
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = model_row(i, 0);
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    row_count = '0;
    m_tready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd_en", bram_r_rd_en, 0);
    check_eq("rst_rd_addr", bram_r_rd_addr, 0);
    check_eq("rst_tvalid", m_tvalid, 0);
    check_eq("rst_tlast", m_tlast, 0);
    check_eq("rst_tdata", m_tdata, 0);

    run_drain(0, 50, 1'b0, 0);
    run_drain(0, 50, 1'b1, 0);
    run_drain(1022, 4, 1'b0, 0);
    run_drain(0, 0, 1'b0, 0);
    run_drain(0, 50, 1'b0, 10);
    run_drain(0, 5, 1'b0, 0);
    run_drain(1023, 1, 1'b1, 0);
    for (int k = 0; k < 4; k++) begin
      run_drain(int'($urandom % DEPTH), 1 + int'($urandom % 60), 1'($urandom % 2), 0);
    end
    run_drain(1000, 1030, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/result_drain.md
Name: result_drain

Overview:
- Reader side of the result BRAM (BRAM R): after the datapath finishes, it pulls result rows out of BRAM R.
- Streams the rows to the PS over a valid/ready stream, one row (PE_COUNT lanes) per beat.
- Replaces manual per-address polling of bram_r_r_addr/bram_r_r_data; sits between BRAM R's read port and the PS-side DMA/stream interface.
- Hides BRAM read latency with an internal prefetch FIFO so it sustains one beat per cycle under continuous tready.

Parameters:
- PE_COUNT, 4, lanes per row.
- DATA_WIDTH, 32, bits per lane.
- BRAM_DEPTH, 1024, rows in BRAM R.
- ADDR_WIDTH, $clog2(BRAM_DEPTH), BRAM R address width.
- RD_LAT, 2, BRAM R read latency in cycles (rd_en to data valid).
- FIFO_DEPTH, 4, prefetch FIFO entries; must be >= RD_LAT+1 (elaboration-time assertion).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a drain; ignored while busy=1.
- base_addr  in  ADDR_WIDTH  first row address; sampled on start.
- row_count  in  ADDR_WIDTH+1  number of rows to send; sampled on start.
- busy  out  1  high from the cycle after an accepted start until the done pulse.
- done  out  1  one-cycle pulse after the final beat handshake.
- bram_r_rd_en  out  1  BRAM R read enable.
- bram_r_rd_addr  out  ADDR_WIDTH  BRAM R read address.
- bram_r_rd_data  in  PE_COUNT*DATA_WIDTH  BRAM R read data, valid RD_LAT cycles after rd_en.
- m_tdata  out  PE_COUNT*DATA_WIDTH  row data; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  marks the final row of the drain.

Behaviour:
- Reset values: busy, done, bram_r_rd_en, m_tvalid and m_tlast are 0; bram_r_rd_addr and m_tdata are 0. FIFO, in-flight pipe and counters are cleared.
- FSM states are IDLE, RUN and DONE.
- IDLE: on start with row_count>0, latch the address and count and go to RUN.
- IDLE, zero-length start: start with row_count==0 goes to DONE with no reads and no beats (done pulses the next cycle).
- RUN, issuing reads:
  - Issue one read per cycle while issued<row_count and (in_flight + fifo_count) < FIFO_DEPTH.
  - The address increments modulo BRAM_DEPTH, so base_addr=1022 with row_count=4 reads 1022, 1023, 0, 1.
- RUN, capture: a valid-shift pipe of RD_LAT stages tags returning data. Tagged data is pushed into the FIFO on arrival. The credit rule guarantees the FIFO never overflows.
- Stream output:
  - m_tvalid = FIFO not empty; m_tdata = FIFO head.
  - A handshake (m_tvalid & m_tready) pops the head.
  - m_tdata and m_tlast are held stable while m_tvalid=1 and m_tready=0.
- m_tlast is asserted on the beat whose sent count equals row_count-1.
- RUN to DONE: after the last handshake. DONE lasts one cycle (done=1), then returns to IDLE.
- Throughput: with m_tready held at 1, the first beat appears RD_LAT+1 cycles after start, then one beat per cycle with no bubbles.
- Simultaneous push and pop in the same cycle leaves FIFO occupancy unchanged.
- start is ignored while busy=1 or in DONE.
- rst mid-drain aborts immediately: state returns to IDLE, in-flight read data is discarded, no done pulse.
- row_count > BRAM_DEPTH is legal; addresses wrap and rows repeat.

Optional Feature:
- Macro: RESULT_DRAIN_CSUM_EN.
- When defined:
  - Adds output csum [DATA_WIDTH-1:0], the running XOR of every lane of every sent beat.
  - csum clears on an accepted start and on rst, and is stable from the done pulse until the next start.
- When undefined: no csum port and no XOR logic; all other behaviour is identical.

Decomposition:
- Package simd_pkg holds:
  - row_t, a packed [PE_COUNT-1:0][DATA_WIDTH-1:0] array;
  - the drain_state_e enum (IDLE, RUN, DONE);
  - default PE_COUNT/DATA_WIDTH constants shared with datapath_top.
- One sub-module, sync_fifo_row: parameterised-depth synchronous FIFO of row_t with push/pop/empty/count, first-word-fall-through.

Test Plan:
- Preload BRAM R rows 0..49 with lane values {4i, 4i+1, 4i+2, 4i+3}; start with base=0, count=50, tready=1 → 50 contiguous beats with the correct lanes; tlast only on beat 49; done pulses once.
- Same preload, tready toggling at 50% random → identical data order, no drops or duplicates, tdata stable while stalled, FIFO count never exceeds 4.
- base=1022, count=4 → beats carry rows 1022, 1023, 0, 1.
- count=0 → no rd_en and no tvalid; done pulses 1 cycle after start.
- Assert rst after 10 beats of a 50-row drain, then start again with count=5 → no done for the aborted run; new run sends rows 0..4 cleanly.
- With RESULT_DRAIN_CSUM_EN defined, row i lanes={i,0,0,0} for i=1..3, count=3 (base=1) → csum=0 at done (1^2^3).
